// File: rtl/imem_dmem_responder.sv
// Memory-side responder for the core fetch/store port: one request at a time,
// word-addressed 64-bit array, response after a fixed LATENCY.
module imem_dmem_responder #(
    parameter int          DEPTH_LOG2 = 12,
    parameter int          LATENCY    = 2,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic [31:0] resp_inst,
    output logic        resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int          DEPTH   = 1 << DEPTH_LOG2;
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam logic [63:0] SPAN    = 64'(DEPTH) * 64'd8;
    localparam bit          ONE_CYC = (LATENCY == 1);

    state_t          r_state;
    logic [3:0]      r_cnt;
    logic [63:0]     r_addr;
    logic            r_wen;
    logic [63:0]     r_wdata;
    logic [7:0]      r_wmask;
    logic            r_req_ready;
    logic            r_resp_valid;
    logic [63:0]     r_rdata;
    logic [31:0]     r_inst;
    logic            r_err;
    logic [63:0]     r_mem [DEPTH];

    logic                  w_idle;
    logic                  w_hs;
    logic                  w_commit;
    logic [63:0]           w_addr;
    logic                  w_wen;
    logic [63:0]           w_wdata;
    logic [7:0]            w_wmask;
    logic [63:0]           w_off;
    logic                  w_oor;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [63:0]           w_word;
    logic [63:0]           w_rdata;
    logic [31:0]           w_inst;

    assign w_idle = (r_state == S_IDLE);
    assign w_hs   = req_valid & r_req_ready;

    // With LATENCY=1 the commit happens on the accepting edge, so it must
    // see the live request fields rather than the latched copy.
    assign w_addr  = w_idle ? req_addr  : r_addr;
    assign w_wen   = w_idle ? req_wen   : r_wen;
    assign w_wdata = w_idle ? req_wdata : r_wdata;
    assign w_wmask = w_idle ? req_wmask : r_wmask;

    assign w_commit = (w_idle && w_hs && ONE_CYC)
                    || (r_state == S_WAIT && r_cnt == 4'd1);

    assign w_off   = w_addr - BASE_ADDR;
    assign w_oor   = (w_addr < BASE_ADDR) || (w_off >= SPAN);
    assign w_idx   = w_off[DEPTH_LOG2+2:3];
    assign w_word  = r_mem[w_idx];
    assign w_rdata = (w_oor || w_wen) ? 64'd0 : w_word;
    assign w_inst  = w_addr[2] ? w_rdata[63:32] : w_rdata[31:0];

    always_ff @(posedge clk) begin
        if (!rst && w_commit && w_wen && !w_oor) begin
            for (int i = 0; i < 8; i++) begin
                if (w_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_addr       <= 64'd0;
            r_wen        <= 1'b0;
            r_wdata      <= 64'd0;
            r_wmask      <= 8'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_rdata      <= 64'd0;
            r_inst       <= 32'd0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_addr      <= req_addr;
                        r_wen       <= req_wen;
                        r_wdata     <= req_wdata;
                        r_wmask     <= req_wmask;
                        r_cnt       <= LAT_M1;
                        r_req_ready <= 1'b0;
                        if (ONE_CYC) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_rdata      <= w_rdata;
                            r_inst       <= w_inst;
                            r_err        <= w_oor;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_rdata;
                        r_inst       <= w_inst;
                        r_err        <= w_oor;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_inst  = r_inst;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_imem_dmem_responder.sv
// Bench for imem_dmem_responder: three instances (LATENCY 2, 1, 7) checked
// against a word-array model driven by random and directed traffic.
module tb_imem_dmem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          WORDS = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wen [3];
    logic [63:0] req_addr [3];
    logic [63:0] req_wdata [3];
    logic [7:0]  req_wmask [3];
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [63:0] resp_rdata [3];
    logic [31:0] resp_inst [3];
    logic        resp_err [3];

    int          lat_of [3] = '{2, 1, 7};
    logic [63:0] mdl [3][WORDS];
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    imem_dmem_responder #(.DEPTH_LOG2(12), .LATENCY(2), .BASE_ADDR(BASE)) u_l2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_wen(req_wen[0]),
        .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_inst(resp_inst[0]),
        .resp_err(resp_err[0])
    );

    imem_dmem_responder #(.DEPTH_LOG2(12), .LATENCY(1), .BASE_ADDR(BASE)) u_l1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_wen(req_wen[1]),
        .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_inst(resp_inst[1]),
        .resp_err(resp_err[1])
    );

    imem_dmem_responder #(.DEPTH_LOG2(12), .LATENCY(7), .BASE_ADDR(BASE)) u_l7 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr[2]), .req_wen(req_wen[2]),
        .req_wdata(req_wdata[2]), .req_wmask(req_wmask[2]),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_inst(resp_inst[2]),
        .resp_err(resp_err[2])
    );

    task automatic preload(input int k, input logic [11:0] idx, input logic [63:0] v);
        mdl[k][idx] = v;
        case (k)
            0: u_l2.r_mem[idx] = v;
            1: u_l1.r_mem[idx] = v;
            default: u_l7.r_mem[idx] = v;
        endcase
    endtask

    // Reference: flat byte-addressed window of 32 KiB starting at BASE.
    task automatic mdl_op(input int k, input logic [63:0] a, input logic w,
                          input logic [63:0] d, input logic [7:0] m,
                          output logic [63:0] rd, output logic [31:0] ins,
                          output logic er);
        logic [63:0] off;
        logic [11:0] idx;
        off = a - BASE;
        rd  = 64'd0;
        if (a < BASE || off >= 64'd32768) begin
            er = 1'b1;
        end else begin
            er  = 1'b0;
            idx = 12'(off / 64'd8);
            if (w) begin
                for (int i = 0; i < 8; i++)
                    if (m[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
            end else begin
                rd = mdl[k][idx];
            end
        end
        ins = a[2] ? rd[63:32] : rd[31:0];
    endtask

    function automatic logic [63:0] rand_addr();
        int s;
        s = $urandom_range(0, 9);
        if (s == 0) return BASE - 64'(8 * $urandom_range(1, 64));
        if (s == 1) return BASE + 64'd32768 + 64'($urandom_range(0, 4095));
        return BASE + 64'(8 * $urandom_range(0, 15) + $urandom_range(0, 7));
    endfunction

    // One full transaction; lat counts edges from acceptance to first resp_valid.
    task automatic xact(input int k, input logic [63:0] a, input logic w,
                        input logic [63:0] d, input logic [7:0] m,
                        output logic [63:0] rd, output logic [31:0] ins,
                        output logic er, output int lat);
        int g;
        @(negedge clk);
        g = 0;
        while (!req_ready[k] && g < 50) begin
            @(negedge clk);
            g++;
        end
        req_valid[k]  = 1'b1;
        req_addr[k]   = a;
        req_wen[k]    = w;
        req_wdata[k]  = d;
        req_wmask[k]  = m;
        resp_ready[k] = 1'b0;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_addr[k]  = {$urandom, $urandom};
        req_wen[k]   = ~w;
        req_wdata[k] = {$urandom, $urandom};
        req_wmask[k] = 8'($urandom);
        lat = 1;
        @(negedge clk);
        while (!resp_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rd  = resp_rdata[k];
        ins = resp_inst[k];
        er  = resp_err[k];
        resp_ready[k] = 1'b1;
        @(posedge clk);
        #1 resp_ready[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({req_ready[k], resp_valid[k], resp_err[k], resp_inst[k], resp_rdata[k]}
                !== {1'b1, 1'b0, 1'b0, 32'd0, 64'd0})
                $display("FAIL reset_state[%0d]: rdy=%b vld=%b err=%b inst=%h rdata=%h want 1 0 0 0 0",
                         k, req_ready[k], resp_valid[k], resp_err[k], resp_inst[k], resp_rdata[k]);
            else n_pass++;
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0)
            $display("FAIL post_reset_idle: rdy=%b vld=%b want 1 0", req_ready[0], resp_valid[0]);
        else n_pass++;
    endtask

    task automatic test_basic_read();
        logic [63:0] rd, erd;
        logic [31:0] ins, eins;
        logic er, eer;
        int lat;
        preload(0, 12'd0, 64'h0000_0413_0000_0093);
        mdl_op(0, BASE, 1'b0, 64'd0, 8'd0, erd, eins, eer);
        xact(0, BASE, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (lat !== 2) $display("FAIL basic_latency: got %0d want 2", lat);
        else n_pass++;
        n_chk++;
        if (ins !== 32'h0000_0093 || er !== 1'b0)
            $display("FAIL basic_inst_lo: inst=%h err=%b want 00000093 0", ins, er);
        else n_pass++;
        n_chk++;
        if (rd !== 64'h0000_0413_0000_0093)
            $display("FAIL basic_rdata: got %h want 0000041300000093", rd);
        else n_pass++;
        xact(0, BASE + 64'd4, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (ins !== 32'h0000_0413 || er !== 1'b0)
            $display("FAIL basic_inst_hi: inst=%h err=%b want 00000413 0", ins, er);
        else n_pass++;
    endtask

    task automatic test_masked_write();
        logic [63:0] rd, erd;
        logic [31:0] ins, eins;
        logic er, eer;
        int lat;
        preload(0, 12'd5, 64'hFFFF_FFFF_FFFF_FFFF);
        mdl_op(0, BASE + 64'h28, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, erd, eins, eer);
        xact(0, BASE + 64'h28, 1'b1, 64'h1122_3344_5566_7788, 8'h0F, rd, ins, er, lat);
        n_chk++;
        if (rd !== 64'd0 || er !== 1'b0)
            $display("FAIL write_resp: rdata=%h err=%b want 0 0", rd, er);
        else n_pass++;
        mdl_op(0, BASE + 64'h28, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00, erd, eins, eer);
        xact(0, BASE + 64'h28, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 8'h00, rd, ins, er, lat);
        mdl_op(0, BASE + 64'h28, 1'b0, 64'd0, 8'd0, erd, eins, eer);
        xact(0, BASE + 64'h28, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (rd !== 64'hFFFF_FFFF_5566_7788)
            $display("FAIL masked_readback: got %h want ffffffff55667788", rd);
        else n_pass++;
        n_chk++;
        if (rd !== erd) $display("FAIL masked_model: got %h want %h", rd, erd);
        else n_pass++;
    endtask

    task automatic test_out_of_range();
        logic [63:0] rd, erd;
        logic [31:0] ins, eins;
        logic er, eer;
        int lat;
        int bad;
        xact(0, 64'h7FFF_FFF8, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (er !== 1'b1 || rd !== 64'd0 || ins !== 32'd0)
            $display("FAIL oor_read_low: err=%b rdata=%h inst=%h want 1 0 0", er, rd, ins);
        else n_pass++;
        xact(0, BASE - 64'd1, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (er !== 1'b1) $display("FAIL oor_base_minus1: err=%b want 1", er);
        else n_pass++;
        xact(0, 64'h8000_8000, 1'b1, {$urandom, $urandom}, 8'hFF, rd, ins, er, lat);
        n_chk++;
        if (er !== 1'b1 || rd !== 64'd0)
            $display("FAIL oor_write: err=%b rdata=%h want 1 0", er, rd);
        else n_pass++;
        mdl_op(0, BASE + 64'h7FFF, 1'b0, 64'd0, 8'd0, erd, eins, eer);
        xact(0, BASE + 64'h7FFF, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (er !== 1'b0 || rd !== erd || ins !== eins)
            $display("FAIL last_word_read: err=%b rdata=%h inst=%h want 0 %h %h", er, rd, ins, erd, eins);
        else n_pass++;
        bad = 0;
        for (int i = 0; i < WORDS; i++) begin
            xact(0, BASE + 64'(8 * i), 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
            if (rd !== mdl[0][i] || er !== 1'b0) bad++;
        end
        n_chk++;
        if (bad !== 0) $display("FAIL oor_array_intact: got %0d changed words want 0", bad);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [63:0] a, rd, erd, ord;
        logic [31:0] ins, eins, oins;
        logic er, eer, oer;
        int g, lat;
        a = BASE + 64'(8 * $urandom_range(8, 15)) + 64'd4;
        mdl_op(0, a, 1'b0, 64'd0, 8'd0, erd, eins, eer);
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_addr[0]   = a;
        req_wen[0]    = 1'b0;
        resp_ready[0] = 1'b0;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        g = 0;
        @(negedge clk);
        while (!resp_valid[0] && g < 40) begin
            @(negedge clk);
            g++;
        end
        req_valid[0] = 1'b1;
        req_addr[0]  = BASE + 64'd56;
        req_wen[0]   = 1'b1;
        req_wdata[0] = {$urandom, $urandom};
        req_wmask[0] = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            n_chk++;
            if ({resp_valid[0], req_ready[0], resp_err[0], resp_inst[0], resp_rdata[0]}
                !== {1'b1, 1'b0, eer, eins, erd})
                $display("FAIL stall_cycle%0d: vld=%b rdy=%b err=%b inst=%h rdata=%h want 1 0 %b %h %h",
                         c, resp_valid[0], req_ready[0], resp_err[0], resp_inst[0], resp_rdata[0],
                         eer, eins, erd);
            else n_pass++;
            if (c < 5) @(negedge clk);
        end
        resp_ready[0] = 1'b1;
        req_valid[0]  = 1'b0;
        @(posedge clk);
        #1 resp_ready[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (resp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1)
            $display("FAIL release_to_idle: vld=%b rdy=%b want 0 1", resp_valid[0], req_ready[0]);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++;
        if (resp_valid[0] !== 1'b0) $display("FAIL no_phantom_resp: vld=%b want 0", resp_valid[0]);
        else n_pass++;
        mdl_op(0, BASE + 64'd56, 1'b0, 64'd0, 8'd0, ord, oins, oer);
        xact(0, BASE + 64'd56, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (rd !== ord) $display("FAIL ignored_write: word7=%h want %h", rd, ord);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] rd;
        logic [31:0] ins;
        logic er;
        int lat;
        preload(0, 12'd3, 64'hDEAD_BEEF_0BAD_F00D);
        @(negedge clk);
        req_valid[0]  = 1'b1;
        req_addr[0]   = BASE + 64'd24;
        req_wen[0]    = 1'b1;
        req_wdata[0]  = {$urandom, $urandom};
        req_wmask[0]  = 8'hFF;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        n_chk++;
        if (req_ready[0] !== 1'b0 || resp_valid[0] !== 1'b0)
            $display("FAIL busy_in_wait: rdy=%b vld=%b want 0 0", req_ready[0], resp_valid[0]);
        else n_pass++;
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if ({req_ready[0], resp_valid[0], resp_err[0], resp_inst[0], resp_rdata[0]}
            !== {1'b1, 1'b0, 1'b0, 32'd0, 64'd0})
            $display("FAIL async_clear: rdy=%b vld=%b err=%b inst=%h rdata=%h want 1 0 0 0 0",
                     req_ready[0], resp_valid[0], resp_err[0], resp_inst[0], resp_rdata[0]);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        resp_ready[0] = 1'b0;
        xact(0, BASE + 64'd24, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (rd !== 64'hDEAD_BEEF_0BAD_F00D || er !== 1'b0)
            $display("FAIL dropped_write: word3=%h err=%b want deadbeef0badf00d 0", rd, er);
        else n_pass++;
        xact(0, BASE + 64'd28, 1'b0, 64'd0, 8'd0, rd, ins, er, lat);
        n_chk++;
        if (ins !== 32'hDEAD_BEEF) $display("FAIL dropped_write_inst: got %h want deadbeef", ins);
        else n_pass++;
    endtask

    task automatic test_random(input int k, input int n);
        logic [63:0] a, d, rd, erd;
        logic [31:0] ins, eins;
        logic [7:0] m;
        logic w, er, eer;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = rand_addr();
            w = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            m = 8'($urandom);
            mdl_op(k, a, w, d, m, erd, eins, eer);
            xact(k, a, w, d, m, rd, ins, er, lat);
            n_chk++;
            if (lat !== lat_of[k])
                $display("FAIL rand_lat[%0d.%0d]: got %0d want %0d", k, i, lat, lat_of[k]);
            else n_pass++;
            n_chk++;
            if (rd !== erd || ins !== eins || er !== eer)
                $display("FAIL rand_resp[%0d.%0d] a=%h w=%b: rdata=%h inst=%h err=%b want %h %h %b",
                         k, i, a, w, rd, ins, er, erd, eins, eer);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back(input int k);
        int          acc[$];
        logic [63:0] q[$];
        logic [63:0] erd, want;
        logic [31:0] eins;
        logic        eer;
        int t, n, got;
        t = 0;
        n = 0;
        got = 0;
        @(negedge clk);
        resp_ready[k] = 1'b1;
        req_valid[k]  = 1'b1;
        req_wen[k]    = 1'b0;
        req_wdata[k]  = 64'd0;
        req_wmask[k]  = 8'd0;
        req_addr[k]   = BASE + 64'(8 * $urandom_range(0, 15));
        while ((n < 6 || got < 6) && t < 200) begin
            if (resp_valid[k] && resp_ready[k]) begin
                want = (q.size() > 0) ? q.pop_front() : 64'hX;
                got++;
                n_chk++;
                if (resp_rdata[k] !== want)
                    $display("FAIL b2b_data[%0d.%0d]: got %h want %h", k, got, resp_rdata[k], want);
                else n_pass++;
            end
            if (req_valid[k] && req_ready[k]) begin
                acc.push_back(t);
                mdl_op(k, req_addr[k], 1'b0, 64'd0, 8'd0, erd, eins, eer);
                q.push_back(erd);
                n++;
            end
            @(posedge clk);
            #1;
            if (n >= 6) req_valid[k] = 1'b0;
            else req_addr[k] = BASE + 64'(8 * $urandom_range(0, 15) + $urandom_range(0, 7));
            @(negedge clk);
            t++;
        end
        req_valid[k]  = 1'b0;
        resp_ready[k] = 1'b0;
        n_chk++;
        if (n !== 6 || got !== 6)
            $display("FAIL b2b_done[%0d]: accepted %0d responded %0d want 6 6", k, n, got);
        else n_pass++;
        for (int i = 1; i < acc.size(); i++) begin
            n_chk++;
            if (acc[i] - acc[i-1] !== lat_of[k] + 1)
                $display("FAIL b2b_interval[%0d.%0d]: got %0d want %0d",
                         k, i, acc[i] - acc[i-1], lat_of[k] + 1);
            else n_pass++;
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req_valid[k]  = 1'b0;
            resp_ready[k] = 1'b0;
            req_addr[k]   = 64'd0;
            req_wen[k]    = 1'b0;
            req_wdata[k]  = 64'd0;
            req_wmask[k]  = 8'd0;
            for (int i = 0; i < WORDS; i++) preload(k, 12'(i), {$urandom, $urandom});
        end
        test_reset();
        test_basic_read();
        test_masked_write();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_random(0, 20);
        test_random(1, 20);
        test_random(2, 12);
        test_back_to_back(0);
        test_back_to_back(1);
        test_back_to_back(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
